// File: rtl/twiddle_mult25.sv
// Inter-stage twiddle multiplier for a 5x5 25-point DFT: x[i] * W25^(r*c), Q10 twiddles, 4-stage pipeline.
// Optional clamp of the rounded result is enabled by defining TWMUL_SAT_EN (default: two's-complement wrap).

module twiddle25 #(
  parameter int TW_FF = 1
) (
  input  logic              clk,
  input  logic [4:0]        i_addr,
  output logic signed [11:0] o_re,
  output logic signed [11:0] o_im
);
  logic signed [11:0] w_re;
  logic signed [11:0] w_im;

  // W25^k = floor(1024*cos(2*pi*k/25)), floor(-1024*sin(2*pi*k/25)); only k = 0..16 is ever addressed.
  always_comb begin
    {w_re, w_im} = {12'sd1024, 12'sd0};
    case (i_addr)
      5'd1:  {w_re, w_im} = {12'sd991,   -12'sd255};
      5'd2:  {w_re, w_im} = {12'sd897,   -12'sd494};
      5'd3:  {w_re, w_im} = {12'sd746,   -12'sd701};
      5'd4:  {w_re, w_im} = {12'sd548,   -12'sd865};
      5'd5:  {w_re, w_im} = {12'sd316,   -12'sd974};
      5'd6:  {w_re, w_im} = {12'sd64,    -12'sd1022};
      5'd7:  {w_re, w_im} = {-12'sd192,  -12'sd1006};
      5'd8:  {w_re, w_im} = {-12'sd436,  -12'sd927};
      5'd9:  {w_re, w_im} = {-12'sd653,  -12'sd790};
      5'd10: {w_re, w_im} = {-12'sd829,  -12'sd602};
      5'd11: {w_re, w_im} = {-12'sd953,  -12'sd377};
      5'd12: {w_re, w_im} = {-12'sd1016, -12'sd129};
      5'd13: {w_re, w_im} = {-12'sd1016, 12'sd128};
      5'd14: {w_re, w_im} = {-12'sd953,  12'sd376};
      5'd15: {w_re, w_im} = {-12'sd829,  12'sd601};
      5'd16: {w_re, w_im} = {-12'sd653,  12'sd789};
      default: {w_re, w_im} = {12'sd1024, 12'sd0};
    endcase
  end

  generate
    if (TW_FF != 0) begin : g_ff
      logic signed [11:0] r_re;
      logic signed [11:0] r_im;
      always_ff @(posedge clk) begin
        r_re <= w_re;
        r_im <= w_im;
      end
      assign o_re = r_re;
      assign o_im = r_im;
    end else begin : g_comb
      assign o_re = w_re;
      assign o_im = w_im;
    end
  endgenerate
endmodule

module twiddle_mult25 #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_last
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic signed [SW-1:0] C_HALF = SW'(512);
`ifdef TWMUL_SAT_EN
  localparam logic signed [SW-1:0] C_MAX = SW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] C_MIN = SW'(-(2 ** (WIDTH - 1)));
`endif

  // Handshake: di_en is a one-way valid with no ready; every cycle with di_en high (and rst low)
  // consumes one sample, and do_en is that valid delayed by exactly four cycles.
  logic [2:0] r_col, r_row;
  logic [4:0] r_addr;
  logic       r_s1_en, r_s1_last, r_s2_en, r_s2_last, r_s3_en, r_s3_last, r_do_en, r_do_last;
  logic [4:0] r_s1_addr;
  logic signed [WIDTH-1:0] r_s1_re, r_s1_im, r_s2_re, r_s2_im;
  logic signed [PW-1:0]    r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic [WIDTH-1:0]        r_do_re, r_do_im;
  logic signed [11:0]      w_tw_re, w_tw_im;
  logic signed [PW-1:0]    w_x_re, w_x_im, w_t_re, w_t_im;
  logic signed [SW-1:0]    w_sum_re, w_sum_im;

  function automatic logic [WIDTH-1:0] fit_round(input logic signed [SW-1:0] s);
`ifdef TWMUL_SAT_EN
    logic signed [SW-1:0] v;
    v = (s + C_HALF) >>> 10;
    if (v > C_MAX)      return WIDTH'(C_MAX);
    else if (v < C_MIN) return WIDTH'(C_MIN);
    else                return v[WIDTH-1:0];
`else
    return WIDTH'((s + C_HALF) >>> 10);
`endif
  endfunction

  // Address r*c built incrementally: addr steps by the row number and clears at each row end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_addr    <= '0;
      r_s1_en   <= 1'b0;
      r_s1_last <= 1'b0;
      r_s2_en   <= 1'b0;
      r_s2_last <= 1'b0;
      r_s3_en   <= 1'b0;
      r_s3_last <= 1'b0;
      r_do_en   <= 1'b0;
      r_do_last <= 1'b0;
      r_do_re   <= '0;
      r_do_im   <= '0;
    end else begin
      r_s1_en   <= di_en;
      r_s1_last <= di_en && (r_row == 3'd4) && (r_col == 3'd4);
      if (di_en) begin
        if (r_col == 3'd4) begin
          r_col  <= '0;
          r_addr <= '0;
          r_row  <= (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
        end else begin
          r_col  <= r_col + 3'd1;
          r_addr <= r_addr + 5'(r_row);
        end
      end
      r_s2_en   <= r_s1_en;
      r_s2_last <= r_s1_last;
      r_s3_en   <= r_s2_en;
      r_s3_last <= r_s2_last;
      r_do_en   <= r_s3_en;
      r_do_last <= r_s3_en && r_s3_last;
      if (r_s3_en) begin
        r_do_re <= fit_round(w_sum_re);
        r_do_im <= fit_round(w_sum_im);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (di_en) begin
      r_s1_re   <= di_re;
      r_s1_im   <= di_im;
      r_s1_addr <= r_addr;
    end
    r_s2_re <= r_s1_re;
    r_s2_im <= r_s1_im;
    r_p_rr  <= w_x_re * w_t_re;
    r_p_ii  <= w_x_im * w_t_im;
    r_p_ri  <= w_x_re * w_t_im;
    r_p_ir  <= w_x_im * w_t_re;
  end

  twiddle25 #(.TW_FF(1)) u_tw (
    .clk    (clk),
    .i_addr (r_s1_addr),
    .o_re   (w_tw_re),
    .o_im   (w_tw_im)
  );

  assign w_x_re = {{WIDTH{r_s2_re[WIDTH-1]}}, r_s2_re};
  assign w_x_im = {{WIDTH{r_s2_im[WIDTH-1]}}, r_s2_im};
  assign w_t_re = {{(PW-12){w_tw_re[11]}}, w_tw_re};
  assign w_t_im = {{(PW-12){w_tw_im[11]}}, w_tw_im};

  assign w_sum_re = {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
  assign w_sum_im = {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};

  assign do_en   = r_do_en;
  assign do_last = r_do_last;
  assign do_re   = r_do_re;
  assign do_im   = r_do_im;
endmodule
